lstm_gate_seq: RTL and testbench

Sequenced, parametrised LSTM gate unit: consumes a stream of (x, w) and (h, u) operand beats, accumulates both dot products with saturation, adds a bias, and applies a run-time-selectable sigmoid or tanh activation. It is the next-generation replacement for the fixed single-activation gate cell. It generalises vector lengths and activation mode, and adds a start/valid/ready handshake so the LSTM cell controller no longer drives the accumulate enables directly.

---
 rtl/lstm_pkg.sv | 49 ++++
 rtl/lstm_gate_seq_act_plan.sv | 34 +++
 rtl/lstm_gate_seq_mac_sat.sv | 38 +++
 rtl/lstm_gate_seq.sv | 108 ++++++++++
 tb/tb_lstm_gate_seq.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/lstm_pkg.sv
// Shared types, fixed-point constants and saturation helpers for the LSTM gate and cell blocks.
package lstm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACC,
    ST_SUM,
    ST_ACT,
    ST_DONE
  } state_t;

  localparam int     FRAC_DEF = 20;
  localparam longint ONE      = longint'(1) <<< FRAC_DEF;

  // Sigmoid breakpoints and offsets held in units of 1/32 so any FRAC >= 5 can rescale them exactly.
  localparam longint ONE_Q5     = 32;
  localparam longint BP_HI_Q5   = 160;  // 5.0
  localparam longint BP_MID_Q5  = 76;   // 2.375
  localparam longint BP_LO_Q5   = 32;   // 1.0
  localparam longint OFS_HI_Q5  = 27;   // 0.84375
  localparam longint OFS_MID_Q5 = 20;   // 0.625
  localparam longint OFS_LO_Q5  = 16;   // 0.5
  localparam int     SH_HI      = 5;    // slope 1/32
  localparam int     SH_MID     = 3;    // slope 1/8
  localparam int     SH_LO      = 2;    // slope 1/4

  function automatic longint fx(input longint q5, input int frac);
    return q5 <<< (frac - 5);
  endfunction

  function automatic longint sat_w(input longint v, input int w);
    longint hi, lo;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -(longint'(1) <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic longint sat_add(input longint a, input longint b, input int w);
    return sat_w(a + b, w);
  endfunction

  // Arithmetic shift floors toward -inf before clamping back to the word.
  function automatic longint sat_trunc(input longint p, input int frac, input int w);
    return sat_w(p >>> frac, w);
  endfunction

endpackage

// File: rtl/lstm_gate_seq_act_plan.sv
// Piecewise-linear sigmoid; tanh reuses it as 2*sigm(sat(2s)) - 1.
module act_plan
  import lstm_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int FRAC  = 20
) (
  input  logic signed [WIDTH-1:0] s,
  input  logic                    mode,
  output logic signed [WIDTH-1:0] y
);

  localparam longint K_ONE   = fx(ONE_Q5, FRAC);
  localparam longint K_BP_HI = fx(BP_HI_Q5, FRAC);
  localparam longint K_BP_MD = fx(BP_MID_Q5, FRAC);
  localparam longint K_BP_LO = fx(BP_LO_Q5, FRAC);
  localparam longint K_OF_HI = fx(OFS_HI_Q5, FRAC);
  localparam longint K_OF_MD = fx(OFS_MID_Q5, FRAC);
  localparam longint K_OF_LO = fx(OFS_LO_Q5, FRAC);

  longint z, a, sg;

  always_comb begin
    z = mode ? sat_add(longint'(s), longint'(s), WIDTH) : longint'(s);
    a = (z < 0) ? -z : z;
    if (a >= K_BP_HI)      sg = K_ONE;
    else if (a >= K_BP_MD) sg = (a >>> SH_HI) + K_OF_HI;
    else if (a >= K_BP_LO) sg = (a >>> SH_MID) + K_OF_MD;
    else                   sg = (a >>> SH_LO) + K_OF_LO;
    if (z < 0) sg = K_ONE - sg;
    y = mode ? WIDTH'(2 * sg - K_ONE) : WIDTH'(sg);
  end

endmodule

// File: rtl/lstm_gate_seq_mac_sat.sv
// One saturating multiply-accumulate lane: product, floor shift, clamp, saturating accumulate.
module mac_sat
  import lstm_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int FRAC  = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    beat,
  input  logic                    act,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] acc,
  output logic signed [WIDTH-1:0] mul
);

  logic signed [2*WIDTH-1:0] prod;
  logic signed [WIDTH-1:0]   p_sat;

  assign prod  = a * b;
  assign p_sat = WIDTH'(sat_trunc(longint'(prod), FRAC, WIDTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      mul <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (beat) begin
      // An inactive lane still reports a zero product for the beat.
      mul <= act ? p_sat : '0;
      if (act) acc <= WIDTH'(sat_add(longint'(acc), longint'(p_sat), WIDTH));
    end
  end

endmodule

// File: rtl/lstm_gate_seq.sv
// Sequenced LSTM gate: streams x/w and h/u beats, sums with bias, applies sigmoid or tanh.
module lstm_gate_seq
  import lstm_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int FRAC  = 20,
  parameter int NX    = 53,
  parameter int NH    = 53
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_mode,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_w,
  input  logic [WIDTH-1:0] i_h,
  input  logic [WIDTH-1:0] i_u,
  output logic             o_busy,
  output logic [WIDTH-1:0] o_mul_1,
  output logic [WIDTH-1:0] o_mul_2,
  output logic [WIDTH-1:0] o_act,
  output logic             o_valid
);

  localparam int NMAX = (NX > NH) ? NX : NH;
  localparam int CW   = $clog2(NMAX + 1);

  state_t                  state, state_nxt;
  logic [CW-1:0]           cnt;
  logic                    mode_q;
  logic signed [WIDTH-1:0] b_q, s_q, acc_x, acc_h, act_y;
  logic                    beat, clr, last, x_on, h_on;

  assign beat = (state == ST_ACC) && i_valid;
  assign clr  = (state == ST_IDLE) && i_start;
  assign last = beat && (cnt == CW'(NMAX - 1));
  assign x_on = cnt < CW'(NX);
  assign h_on = cnt < CW'(NH);

  mac_sat #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mac_x (
    .clk(clk), .rst(rst), .clr(clr), .beat(beat), .act(x_on),
    .a(i_x), .b(i_w), .acc(acc_x), .mul(o_mul_1)
  );

  mac_sat #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mac_h (
    .clk(clk), .rst(rst), .clr(clr), .beat(beat), .act(h_on),
    .a(i_h), .b(i_u), .acc(acc_h), .mul(o_mul_2)
  );

  act_plan #(.WIDTH(WIDTH), .FRAC(FRAC)) u_act (
    .s(s_q), .mode(mode_q), .y(act_y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    o_ready   = 1'b0;
    o_valid   = 1'b0;
    o_busy    = 1'b1;
    unique case (state)
      ST_IDLE: begin
        o_busy = 1'b0;
        if (i_start) state_nxt = ST_ACC;
      end
      ST_ACC: begin
        o_ready = 1'b1;
        if (last) state_nxt = ST_SUM;
      end
      ST_SUM:  state_nxt = ST_ACT;
      ST_ACT:  state_nxt = ST_DONE;
      ST_DONE: begin
        o_valid   = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      mode_q <= 1'b0;
      b_q    <= '0;
      s_q    <= '0;
      o_act  <= '0;
    end else begin
      if (clr) begin
        cnt    <= '0;
        mode_q <= i_mode;
        b_q    <= i_b;
      end else if (beat) begin
        cnt <= cnt + 1'b1;
      end
      // Three-term sum is exact in 64 bits, so only one clamp is applied.
      if (state == ST_SUM)
        s_q <= WIDTH'(sat_add(longint'(acc_x) + longint'(acc_h), longint'(b_q), WIDTH));
      if (state == ST_ACT) o_act <= act_y;
    end
  end

endmodule

// File: tb/tb_lstm_gate_seq.sv
// Scoreboard bench: two gate instances (NX=NH=2 and NX=3/NH=1) against a fixed-point reference.
module tb_lstm_gate_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  start, valid;
  logic        mode;
  logic [23:0] b, x, w, h, u;
  logic [1:0]  rdy, busy, ov;
  logic [1:0][23:0] mul1, mul2, act;

  logic [23:0] vx[3], vw[3], vh[3], vu[3];
  logic [23:0] q0[$], q1[$];
  int vcnt[2];
  int errs = 0, checks = 0;

  always #5 clk = ~clk;

  lstm_gate_seq #(.WIDTH(24), .FRAC(20), .NX(2), .NH(2)) u_a (
    .clk(clk), .rst(rst), .i_start(start[0]), .i_mode(mode), .i_b(b),
    .i_valid(valid[0]), .o_ready(rdy[0]), .i_x(x), .i_w(w), .i_h(h), .i_u(u),
    .o_busy(busy[0]), .o_mul_1(mul1[0]), .o_mul_2(mul2[0]), .o_act(act[0]), .o_valid(ov[0])
  );

  lstm_gate_seq #(.WIDTH(24), .FRAC(20), .NX(3), .NH(1)) u_b (
    .clk(clk), .rst(rst), .i_start(start[1]), .i_mode(mode), .i_b(b),
    .i_valid(valid[1]), .o_ready(rdy[1]), .i_x(x), .i_w(w), .i_h(h), .i_u(u),
    .o_busy(busy[1]), .o_mul_1(mul1[1]), .o_mul_2(mul2[1]), .o_act(act[1]), .o_valid(ov[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic longint clampw(input longint v);
    if (v > 8388607)  return 8388607;
    if (v < -8388608) return -8388608;
    return v;
  endfunction

  function automatic longint sx(input logic [23:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint prod(input logic [23:0] p, input logic [23:0] q);
    return clampw((sx(p) * sx(q)) >>> 20);
  endfunction

  function automatic longint sigm(input longint s);
    longint a, y;
    a = (s < 0) ? -s : s;
    if (a >= 'h500000)      y = 'h100000;
    else if (a >= 'h260000) y = a / 32 + 'h0D8000;
    else if (a >= 'h100000) y = a / 8 + 'h0A0000;
    else                    y = a / 4 + 'h080000;
    return (s < 0) ? 'h100000 - y : y;
  endfunction

  function automatic logic [23:0] act_ref(input logic md, input longint s);
    if (md) return 24'(2 * sigm(clampw(2 * s)) - 'h100000);
    return 24'(sigm(s));
  endfunction

  function automatic logic [23:0] rnd();
    logic [21:0] r;
    r = 22'($urandom);
    return {{2{r[21]}}, r};
  endfunction

  always @(negedge clk) begin
    if (ov[0]) begin
      vcnt[0]++;
      chk("q0_nonempty", 32'(q0.size() > 0), 1);
      if (q0.size() > 0) chk("act0", act[0], q0.pop_front());
    end
    if (ov[1]) begin
      vcnt[1]++;
      chk("q1_nonempty", 32'(q1.size() > 0), 1);
      if (q1.size() > 0) chk("act1", act[1], q1.pop_front());
    end
  end

  task automatic run(input int sel, input int nx, input int nh, input logic md,
                     input logic [23:0] bb, input bit gaps, input bit stray);
    longint ax, ah, s;
    int n, lat, nv0;
    logic [23:0] e1, e2;
    n  = (nx > nh) ? nx : nh;
    ax = 0;
    ah = 0;
    @(negedge clk);
    mode = md; b = bb; start[sel] = 1'b1;
    @(negedge clk);
    start[sel] = 1'b0; mode = ~md; b = ~bb;
    chk("busy_acc", 32'(busy[sel]), 1);
    chk("ready_acc", 32'(rdy[sel]), 1);
    nv0 = vcnt[sel];
    for (int i = 0; i < n; i++) begin
      if (gaps) while ($urandom_range(0, 2) == 0) @(negedge clk);
      x = vx[i]; w = vw[i]; h = vh[i]; u = vu[i];
      valid[sel] = 1'b1;
      if (stray && i == 1) start[sel] = 1'b1;
      @(negedge clk);
      valid[sel] = 1'b0; start[sel] = 1'b0;
      e1 = (i < nx) ? 24'(prod(vx[i], vw[i])) : 24'h0;
      e2 = (i < nh) ? 24'(prod(vh[i], vu[i])) : 24'h0;
      if (i < nx) ax = clampw(ax + prod(vx[i], vw[i]));
      if (i < nh) ah = clampw(ah + prod(vh[i], vu[i]));
      chk("mul_1", mul1[sel], e1);
      chk("mul_2", mul2[sel], e2);
    end
    s = clampw(ax + ah + sx(bb));
    if (sel == 0) q0.push_back(act_ref(md, s));
    else          q1.push_back(act_ref(md, s));
    lat = 9;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (ov[sel]) begin
        lat = k;
        break;
      end
    end
    chk("latency", 32'(lat), 2);
    @(negedge clk);
    chk("valid_pulse", 32'(ov[sel]), 0);
    chk("busy_idle", 32'(busy[sel]), 0);
    chk("one_valid", 32'(vcnt[sel] - nv0), 1);
  endtask

  task automatic set_ops(input logic [23:0] x0, x1, w0, w1, h0, h1, u0, u1);
    vx[0] = x0; vx[1] = x1; vx[2] = 0;
    vw[0] = w0; vw[1] = w1; vw[2] = 0;
    vh[0] = h0; vh[1] = h1; vh[2] = 0;
    vu[0] = u0; vu[1] = u1; vu[2] = 0;
  endtask

  initial begin
    int nv0;
    rst = 1'b1; start = '0; valid = '0; mode = 1'b0;
    b = '0; x = '0; w = '0; h = '0; u = '0;
    vcnt[0] = 0; vcnt[1] = 0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(rdy), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(ov), 0);
    chk("rst_act", 32'(act[0]), 0);
    chk("rst_mul", 32'(mul1[0] | mul2[0] | mul1[1] | mul2[1]), 0);
    rst = 1'b0;

    // 0.5 + 0.25 + bias 0.25 = 1.0
    set_ops(24'h100000, 24'h080000, 24'h080000, 24'h080000, 0, 0, 0, 0);
    run(0, 2, 2, 1'b0, 24'h040000, 1'b0, 1'b0);
    chk("sigm_1p0", act[0], 24'h0C0000);
    run(0, 2, 2, 1'b1, 24'h040000, 1'b0, 1'b0);
    chk("tanh_1p0", act[0], 24'h0C0000);

    set_ops(24'h700000, 24'h700000, 24'h100000, 24'h100000,
            24'h700000, 24'h700000, 24'h700000, 24'h700000);
    run(0, 2, 2, 1'b0, 24'h0, 1'b0, 1'b0);
    chk("sat_pos", act[0], 24'h100000);
    set_ops(24'h700000, 24'h700000, 24'hF00000, 24'hF00000,
            24'h700000, 24'h700000, 24'h900000, 24'h900000);
    run(0, 2, 2, 1'b0, 24'h0, 1'b0, 1'b0);
    chk("sat_neg", act[0], 24'h000000);

    set_ops(0, 0, 0, 0, 0, 0, 0, 0);
    run(0, 2, 2, 1'b0, 24'h0, 1'b0, 1'b0);
    chk("zero_sigm", act[0], 24'h080000);
    run(0, 2, 2, 1'b1, 24'h0, 1'b0, 1'b0);
    chk("zero_tanh", act[0], 24'h000000);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 3; i++) begin
        vx[i] = rnd(); vw[i] = rnd(); vh[i] = rnd(); vu[i] = rnd();
      end
      run(1, 3, 1, 1'(r), rnd(), 1'b1, 1'b1);
    end

    // Abort after the first beat.
    @(negedge clk);
    mode = 1'b0; b = '0; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    x = 24'h100000; w = 24'h100000; h = 0; u = 0; valid[0] = 1'b1;
    @(negedge clk);
    valid[0] = 1'b0;
    chk("abort_mul", mul1[0], 24'h100000);
    rst = 1'b1;
    #1;
    chk("abort_act", act[0], 0);
    chk("abort_mul1", mul1[0], 0);
    chk("abort_busy", 32'(busy[0]), 0);
    chk("abort_ready", 32'(rdy[0]), 0);
    nv0 = vcnt[0];
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_novalid", 32'(vcnt[0] - nv0), 0);
    chk("abort_idle", 32'(busy[0]), 0);

    set_ops(24'h100000, 24'h080000, 24'h080000, 24'h080000, 0, 0, 0, 0);
    run(0, 2, 2, 1'b0, 24'h040000, 1'b1, 1'b0);
    chk("post_rst", act[0], 24'h0C0000);

    chk("q_drained", 32'(q0.size() + q1.size()), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
